// File: rtl/fix_conv_scheduler.sv
// Round-robin arbiter feeding one shared float->fixed converter; results are returned tagged with their channel.
// Optional macro SIGN_APPLY_EN: apply the float sign and return a signed, clamped result.
module fix_conv_scheduler #(
   parameter int N_CH        = 4,
   parameter int INT_WIDTH   = 12,
   parameter int FRACT_WIDTH = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [N_CH-1:0]                    req_valid,
   output logic [N_CH-1:0]                    req_ready,
   input  logic [32*N_CH-1:0]                 req_data,
   output logic [31:0]                        conv_single,
   input  logic [INT_WIDTH+FRACT_WIDTH-1:0]   conv_fixed,
   output logic                               res_valid,
   input  logic                               res_ready,
   output logic [INT_WIDTH+FRACT_WIDTH-1:0]   res_data,
   output logic [$clog2(N_CH)-1:0]            res_ch,
   output logic                               res_ovf,
   output logic                               busy
);

   localparam int W   = INT_WIDTH + FRACT_WIDTH;
   localparam int IDW = $clog2(N_CH);

   typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

   state_t           state_q, state_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [31:0]      conv_single_q, conv_single_d;
   logic [IDW-1:0]   ch_q, ch_d;
   logic             res_valid_q, res_valid_d;
   logic [W-1:0]     res_data_q, res_data_d;
   logic [IDW-1:0]   res_ch_q, res_ch_d;
   logic             res_ovf_q, res_ovf_d;

   logic             gnt_found;
   logic [IDW-1:0]   gnt_idx;
   logic [31:0]      gnt_data;
   logic             inf_nan;

`ifdef SIGN_APPLY_EN
   localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};

   function automatic logic [W-1:0] clamp_mag(input logic [W-1:0] v);
      return (v > SMAX) ? SMAX : v;
   endfunction
`endif

   // Search starts at rr_ptr so the most recently served channel goes last.
   always_comb begin
      int idx;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      gnt_data  = '0;
      for (int k = 0; k < N_CH; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= N_CH) idx = idx - N_CH;
         if (!gnt_found && req_valid[idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = IDW'(idx);
            gnt_data  = req_data[32*idx +: 32];
         end
      end
   end

   assign inf_nan = (conv_single_q[30:23] == 8'hFF);

   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      conv_single_d = conv_single_q;
      ch_d          = ch_q;
      res_valid_d   = res_valid_q;
      res_data_d    = res_data_q;
      res_ch_d      = res_ch_q;
      res_ovf_d     = res_ovf_q;
      req_ready     = '0;
      case (state_q)
         IDLE: begin
            if (gnt_found) begin
               req_ready[gnt_idx] = 1'b1;
               conv_single_d      = gnt_data;
               ch_d               = gnt_idx;
               rr_ptr_d           = (gnt_idx == IDW'(N_CH-1)) ? '0 : gnt_idx + 1'b1;
               state_d            = CONV;
            end
         end
         CONV: begin
            res_ch_d    = ch_q;
            res_valid_d = 1'b1;
`ifdef SIGN_APPLY_EN
            res_data_d  = conv_single_q[31] ? ('0 - clamp_mag(conv_fixed))
                                            : clamp_mag(conv_fixed);
            res_ovf_d   = inf_nan | (conv_fixed == {W{1'b1}}) | (conv_fixed > SMAX);
`else
            res_data_d  = conv_fixed;
            res_ovf_d   = inf_nan | (conv_fixed == {W{1'b1}});
`endif
            state_d     = HOLD;
         end
         HOLD: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         rr_ptr_q      <= '0;
         conv_single_q <= '0;
         ch_q          <= '0;
         res_valid_q   <= 1'b0;
         res_data_q    <= '0;
         res_ch_q      <= '0;
         res_ovf_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         conv_single_q <= conv_single_d;
         ch_q          <= ch_d;
         res_valid_q   <= res_valid_d;
         res_data_q    <= res_data_d;
         res_ch_q      <= res_ch_d;
         res_ovf_q     <= res_ovf_d;
      end
   end

   assign conv_single = conv_single_q;
   assign res_valid   = res_valid_q;
   assign res_data    = res_data_q;
   assign res_ch      = res_ch_q;
   assign res_ovf     = res_ovf_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_fix_conv_scheduler.sv
// Bench for fix_conv_scheduler: reference float->fixed converter on the shared port, scoreboard on results.
module tb_fix_conv_scheduler;

   localparam int N_CH = 4;
   localparam int INT_WIDTH = 12;
   localparam int FRACT_WIDTH = 4;
   localparam int W = INT_WIDTH + FRACT_WIDTH;

   typedef struct packed {
      logic [1:0]   ch;
      logic [W-1:0] data;
      logic         ovf;
   } exp_t;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [N_CH-1:0]    req_valid = '0;
   logic [N_CH-1:0]    req_ready;
   logic [31:0]        din [N_CH];
   logic [32*N_CH-1:0] req_data;
   logic [31:0]        conv_single;
   logic [W-1:0]       conv_fixed;
   logic               res_valid;
   logic               res_ready = 1'b0;
   logic [W-1:0]       res_data;
   logic [1:0]         res_ch;
   logic               res_ovf;
   logic               busy;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   exp_t sb[$];
   int   gnt_ch[$];
   int   gnt_cyc[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign req_data = {din[3], din[2], din[1], din[0]};

   // Reference converter: truncating magnitude conversion, saturating to all ones.
   function automatic logic [W-1:0] ref_conv(input logic [31:0] f);
      int e, sh;
      logic [63:0] m;
      e = int'(f[30:23]);
      if (e == 255) return '1;
      m = {40'd0, (e != 0), f[22:0]};
      sh = ((e == 0) ? 1 : e) - 150 + FRACT_WIDTH;
      if (sh >= 0) begin
         if (sh > 40) return '1;
         m = m << sh;
      end else begin
         m = (-sh >= 64) ? 64'd0 : (m >> (-sh));
      end
      if (m > ((64'd1 << W) - 64'd1)) return '1;
      return m[W-1:0];
   endfunction

   function automatic exp_t ref_result(input int c, input logic [31:0] f);
      exp_t r;
      logic [W-1:0] fx;
      fx = ref_conv(f);
      r.ch  = 2'(c);
      r.ovf = (f[30:23] == 8'hFF) || (fx == {W{1'b1}});
`ifdef SIGN_APPLY_EN
      if (fx > 16'h7FFF) begin
         fx = 16'h7FFF;
         r.ovf = 1'b1;
      end
      r.data = f[31] ? (16'd0 - fx) : fx;
`else
      r.data = fx;
`endif
      return r;
   endfunction

   assign conv_fixed = ref_conv(conv_single);

   fix_conv_scheduler #(.N_CH(N_CH), .INT_WIDTH(INT_WIDTH), .FRACT_WIDTH(FRACT_WIDTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
      .conv_single(conv_single), .conv_fixed(conv_fixed),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_ch(res_ch), .res_ovf(res_ovf), .busy(busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      if (obs === expv) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, expv, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 20; i++) begin
         if (sb.size() == 0 && !res_valid) break;
         tick();
      end
      check("drain_empty", 32'(sb.size()), 0);
   endtask

   // Handshakes are sampled mid-cycle; they complete on the following rising edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if ((req_valid & req_ready) != '0) begin
            check("ready_onehot", 32'($countones(req_ready)), 1);
            for (int c = 0; c < N_CH; c++)
               if (req_ready[c]) begin
                  sb.push_back(ref_result(c, din[c]));
                  gnt_ch.push_back(c);
                  gnt_cyc.push_back(cyc);
               end
         end
         if (res_valid && res_ready) begin
            if (sb.size() == 0) check("sb_unexpected", 1, 0);
            else begin
               exp_t e;
               e = sb.pop_front();
               check("res_data", 32'(res_data), 32'(e.data));
               check("res_ch", 32'(res_ch), 32'(e.ch));
               check("res_ovf", 32'(res_ovf), 32'(e.ovf));
            end
         end
      end
   end

   initial begin
      logic [W-1:0] hold_data;
      for (int c = 0; c < N_CH; c++) din[c] = '0;

      // Reset state
      tick(); tick();
      check("rst_busy", 32'(busy), 0);
      check("rst_res_valid", 32'(res_valid), 0);
      check("rst_res_data", 32'(res_data), 0);
      check("rst_res_ch", 32'(res_ch), 0);
      check("rst_res_ovf", 32'(res_ovf), 0);
      check("rst_conv_single", conv_single, 0);
      check("rst_req_ready", 32'(req_ready), 0);
      rst_n = 1'b1;
      tick();

      // Single pi request on channel 1
      din[1] = 32'h40490FDB; req_valid = 4'b0010; res_ready = 1'b1;
      #1 check("pi_grant", 32'(req_ready), 32'h2);
      check("pi_idle", 32'(busy), 0);
      tick();
      req_valid = '0;
      check("pi_conv_valid", 32'(res_valid), 0);
      check("pi_conv_busy", 32'(busy), 1);
      check("pi_conv_op", conv_single, 32'h40490FDB);
      check("pi_conv_ready", 32'(req_ready), 0);
      tick();
      check("pi_valid_n2", 32'(res_valid), 1);
      check("pi_data", 32'(res_data), 32'h0032);
      check("pi_ch", 32'(res_ch), 1);
      check("pi_ovf", 32'(res_ovf), 0);
      tick();
      check("pi_back_idle", 32'(busy), 0);
      check("pi_valid_drop", 32'(res_valid), 0);

      // +Inf on channel 2
      din[2] = 32'h7F800000; req_valid = 4'b0100;
      tick();
      req_valid = '0;
      tick();
      check("inf_ovf", 32'(res_ovf), 1);
`ifdef SIGN_APPLY_EN
      check("inf_data", 32'(res_data), 32'h7FFF);
`else
      check("inf_data", 32'(res_data), 32'hFFFF);
`endif
      drain();

      // Consumer stall with all channels requesting
      din[3] = 32'h42C90000; req_valid = 4'b1000; res_ready = 1'b0;
      tick();
      req_valid = 4'b1111;
      tick();
      hold_data = res_data;
      check("stall_first_data", 32'(hold_data), 32'h0648);
      for (int i = 0; i < 10; i++) begin
         check("stall_valid", 32'(res_valid), 1);
         check("stall_data", 32'(res_data), 32'(hold_data));
         check("stall_ch", 32'(res_ch), 3);
         check("stall_ready", 32'(req_ready), 0);
         tick();
      end
      res_ready = 1'b1; req_valid = '0;
      drain();

      // Reset asserted mid-conversion
      din[1] = 32'h3F800000; req_valid = 4'b0010;
      tick();
      check("mid_in_conv", 32'(busy), 1);
      req_valid = '0;
      rst_n = 1'b0;
      #1;
      check("mid_busy", 32'(busy), 0);
      check("mid_conv_single", conv_single, 0);
      check("mid_res_valid", 32'(res_valid), 0);
      check("mid_res_data", 32'(res_data), 0);
      check("mid_res_ch", 32'(res_ch), 0);
      check("mid_res_ovf", 32'(res_ovf), 0);
      check("mid_req_ready", 32'(req_ready), 0);
      sb.delete(); gnt_ch.delete(); gnt_cyc.delete();
      tick();
      rst_n = 1'b1;
      tick();
      din[0] = 32'h3F800000; din[3] = 32'h7FC00000; req_valid = 4'b1001;
      #1 check("rr_ptr_after_rst", 32'(req_ready), 32'h1);
      tick();
      req_valid = 4'b1000;
      tick(); tick(); tick();
      req_valid = '0;
      drain();
      if (gnt_ch.size() == 2) begin
         check("post_rst_g0", 32'(gnt_ch[0]), 0);
         check("post_rst_g1", 32'(gnt_ch[1]), 3);
      end else check("post_rst_grants", 32'(gnt_ch.size()), 2);

      // All channels continuously valid after a fresh reset
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      sb.delete(); gnt_ch.delete(); gnt_cyc.delete();
      tick();
      din[0] = 32'hC0490FDB; din[1] = 32'h46000000;
      din[2] = 32'h00000001; din[3] = 32'h42C90000;
      req_valid = 4'b1111;
      for (int i = 0; i < 14; i++) tick();
      req_valid = '0;
      drain();
      if (gnt_ch.size() >= 5) begin
         for (int i = 0; i < 5; i++) check("rr_order", 32'(gnt_ch[i]), 32'(i % N_CH));
         for (int i = 1; i < 5; i++) check("rr_spacing", 32'(gnt_cyc[i] - gnt_cyc[i-1]), 3);
      end else check("rr_count", 32'(gnt_ch.size()), 5);
`ifdef SIGN_APPLY_EN
      check("neg_pi_ref", 32'(ref_result(0, 32'hC0490FDB).data), 32'hFFCE);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
